// File: rtl/vga_timing_monitor.sv
// Recovers pixel coordinates and line/frame timing from Hsync/Vsync/displayON and tracks lock.
// Outputs are registered with 1-cycle latency; the monitor is a free-running sink with no backpressure.
module vga_timing_monitor #(
  parameter int LOCK_FRAMES = 2,
  parameter int H_TIMEOUT   = 2047,
  parameter int CNT_W       = 11
) (
  input  logic             PixelClock,
  input  logic             Reset_n,
  input  logic             Hsync,
  input  logic             Vsync,
  input  logic             displayON,
  output logic [9:0]       Xpixel,
  output logic [9:0]       Ypixel,
  output logic             pixelValid,
  output logic [CNT_W-1:0] lineLength,
  output logic [9:0]       frameLines,
  output logic             locked,
  output logic             syncError
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(H_TIMEOUT);
  localparam logic [9:0]       PIX_MAX     = '1;
  localparam logic [3:0]       LOCK_N      = 4'(LOCK_FRAMES);

  logic             hs_q, vs_q, de_q;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             valid_q, new_frame_q, new_frame_d;
  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] line_len_q, line_len_d;
  logic [CNT_W-1:0] line_ref_q, line_ref_d;
  logic             ref_vld_q, ref_vld_d;
  logic             line_bad_q, line_bad_d;
  logic [9:0]       line_cnt_q, line_cnt_d;
  logic [9:0]       frame_lines_q, frame_lines_d;
  logic [9:0]       prev_lines_q, prev_lines_d;
  state_t           state_q, state_d;
  logic [3:0]       match_q, match_d, match_nxt;
  logic             vfirst_q, vfirst_d;
  logic             sync_err_q, sync_err_d;

  logic             hfall, vfall, de_rise;
  logic [CNT_W:0]   len_ext;
  logic [CNT_W-1:0] cur_len;
  logic [9:0]       line_cnt_inc;
  logic             line_mis, frame_ok, timeout;

  assign hfall   = hs_q & ~Hsync;
  assign vfall   = vs_q & ~Vsync;
  assign de_rise = ~de_q & displayON;

  assign len_ext = {1'b0, hcount_q} + (CNT_W+1)'(1);
  assign cur_len = len_ext[CNT_W] ? CNT_MAX : len_ext[CNT_W-1:0];

  // An hFall coinciding with vFall still belongs to the frame being closed.
  assign line_cnt_inc = (hfall && line_cnt_q != PIX_MAX) ? line_cnt_q + 10'd1 : line_cnt_q;
  assign line_mis     = hfall & ref_vld_q & (cur_len != line_ref_q);
  assign frame_ok     = ~(line_bad_q | line_mis) & (line_cnt_inc == prev_lines_q);
  assign timeout      = (hcount_q == TIMEOUT_VAL) & ~hfall;

  always_comb begin
    x_d         = (x_q == PIX_MAX) ? x_q : x_q + 10'd1;
    y_d         = y_q;
    new_frame_d = new_frame_q;
    if (de_rise) begin
      x_d = 10'd0;
      if (new_frame_q) begin
        y_d         = 10'd0;
        new_frame_d = 1'b0;
      end else if (y_q != PIX_MAX) begin
        y_d = y_q + 10'd1;
      end
    end
    if (vfall) new_frame_d = 1'b1;
  end

  always_comb begin
    hcount_d      = (hcount_q == CNT_MAX) ? hcount_q : hcount_q + CNT_W'(1);
    line_len_d    = line_len_q;
    line_ref_d    = line_ref_q;
    ref_vld_d     = ref_vld_q;
    line_bad_d    = line_bad_q | line_mis;
    line_cnt_d    = line_cnt_inc;
    frame_lines_d = frame_lines_q;
    prev_lines_d  = prev_lines_q;
    if (hfall) begin
      hcount_d   = '0;
      line_len_d = cur_len;
    end
    if (vfall) begin
      ref_vld_d     = 1'b0;
      line_bad_d    = 1'b0;
      line_cnt_d    = 10'd0;
      frame_lines_d = line_cnt_inc;
      prev_lines_d  = line_cnt_inc;
    end else if (hfall && !ref_vld_q) begin
      line_ref_d = cur_len;
      ref_vld_d  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    vfirst_d   = vfirst_q;
    sync_err_d = 1'b0;
    match_nxt  = frame_ok ? match_q + 4'd1 : 4'd0;
    if (timeout) begin
      state_d    = SEARCH;
      sync_err_d = (state_q == LOCKED);
    end else begin
      case (state_q)
        SEARCH: begin
          if (vfall) begin
            state_d  = VERIFY;
            match_d  = 4'd0;
            vfirst_d = 1'b1;
          end
        end
        VERIFY: begin
          // The first frame seen in VERIFY only primes prevLines.
          if (vfall) begin
            if (vfirst_q) begin
              vfirst_d = 1'b0;
            end else begin
              match_d = match_nxt;
              if (match_nxt == LOCK_N) state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (line_mis || (vfall && !frame_ok)) begin
            state_d    = SEARCH;
            sync_err_d = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge PixelClock or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      valid_q       <= 1'b0;
      new_frame_q   <= 1'b0;
      hcount_q      <= '0;
      line_len_q    <= '0;
      line_ref_q    <= '0;
      ref_vld_q     <= 1'b0;
      line_bad_q    <= 1'b0;
      line_cnt_q    <= '0;
      frame_lines_q <= '0;
      prev_lines_q  <= '0;
      state_q       <= SEARCH;
      match_q       <= '0;
      vfirst_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      hs_q          <= Hsync;
      vs_q          <= Vsync;
      de_q          <= displayON;
      x_q           <= x_d;
      y_q           <= y_d;
      valid_q       <= displayON;
      new_frame_q   <= new_frame_d;
      hcount_q      <= hcount_d;
      line_len_q    <= line_len_d;
      line_ref_q    <= line_ref_d;
      ref_vld_q     <= ref_vld_d;
      line_bad_q    <= line_bad_d;
      line_cnt_q    <= line_cnt_d;
      frame_lines_q <= frame_lines_d;
      prev_lines_q  <= prev_lines_d;
      state_q       <= state_d;
      match_q       <= match_d;
      vfirst_q      <= vfirst_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign Xpixel     = x_q;
  assign Ypixel     = y_q;
  assign pixelValid = valid_q;
  assign lineLength = line_len_q;
  assign frameLines = frame_lines_q;
  assign locked     = (state_q == LOCKED);
  assign syncError  = sync_err_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor; frame heights are scaled down to keep runtime short.
module tb_vga_timing_monitor;
  logic        PixelClock = 1'b0;
  logic        Reset_n, Hsync, Vsync, displayON;
  logic [9:0]  Xpixel, Ypixel, frameLines;
  logic        pixelValid, locked, syncError;
  logic [10:0] lineLength;

  int n_cmp = 0, n_bad = 0;
  int cyc, err_cnt, err_cyc, lock_rise_cyc;
  logic prev_locked;
  int g_len, g_hsw, g_acts, g_hact, g_vact;
  int line_cyc [16];
  int frame_cyc;
  logic [9:0] first_x, first_y, last_x, last_y;
  logic first_v;

  always #5 PixelClock = ~PixelClock;

  vga_timing_monitor #(.LOCK_FRAMES(2), .H_TIMEOUT(2047), .CNT_W(11)) dut (
    .PixelClock(PixelClock), .Reset_n(Reset_n), .Hsync(Hsync), .Vsync(Vsync),
    .displayON(displayON), .Xpixel(Xpixel), .Ypixel(Ypixel), .pixelValid(pixelValid),
    .lineLength(lineLength), .frameLines(frameLines), .locked(locked), .syncError(syncError)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic hs, input logic vs, input logic de);
    Hsync = hs; Vsync = vs; displayON = de;
    @(posedge PixelClock); #1;
    cyc++;
    if (syncError === 1'b1) begin err_cnt++; err_cyc = cyc; end
    if (locked === 1'b1 && prev_locked !== 1'b1) lock_rise_cyc = cyc;
    prev_locked = locked;
  endtask

  task automatic send_frame(input int lines, input int stretch);
    int len;
    logic hs, vs, de;
    for (int i = 0; i < lines; i++) begin
      len = (i == stretch) ? g_len + 1 : g_len;
      for (int c = 0; c < len; c++) begin
        hs = (c < g_hsw) ? 1'b0 : 1'b1;
        vs = (i < 2) ? 1'b0 : 1'b1;
        de = (i >= 3 && i < 3 + g_vact && c >= g_acts && c < g_acts + g_hact);
        drive(hs, vs, de);
        if (c == 0 && i < 16) line_cyc[i] = cyc;
        if (i == 3 && c == g_acts) begin
          first_x = Xpixel; first_y = Ypixel; first_v = pixelValid;
        end
        if (i == 2 + g_vact && c == g_acts + g_hact - 1) begin
          last_x = Xpixel; last_y = Ypixel;
        end
      end
    end
    frame_cyc = line_cyc[0];
  endtask

  task automatic do_reset();
    Hsync = 1'b1; Vsync = 1'b1; displayON = 1'b0;
    Reset_n = 1'b0;
    @(posedge PixelClock); #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 Reset_n = 1'b0;
    #1;
    n_cmp++; if (Xpixel !== 10'd0) begin n_bad++; $display("FAIL reset_x: got %0d expected 0", Xpixel); end
    n_cmp++; if (Ypixel !== 10'd0) begin n_bad++; $display("FAIL reset_y: got %0d expected 0", Ypixel); end
    n_cmp++; if (pixelValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b expected 0", pixelValid); end
    n_cmp++; if (lineLength !== 11'd0) begin n_bad++; $display("FAIL reset_linelen: got %0d expected 0", lineLength); end
    n_cmp++; if (frameLines !== 10'd0) begin n_bad++; $display("FAIL reset_framelines: got %0d expected 0", frameLines); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    n_cmp++; if (syncError !== 1'b0) begin n_bad++; $display("FAIL reset_syncerr: got %0b expected 0", syncError); end
    @(posedge PixelClock); #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_ideal();
    g_len = 799; g_hsw = 45; g_acts = 100; g_hact = 640; g_vact = 3;
    repeat (3) send_frame(6, -1);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL ideal_unlocked_pre: got %0b expected 0", locked); end
    lock_rise_cyc = -1;
    send_frame(6, -1);
    n_cmp++; if (lock_rise_cyc !== frame_cyc) begin n_bad++; $display("FAIL ideal_lock_cycle: got %0d expected %0d", lock_rise_cyc, frame_cyc); end
    n_cmp++; if (lineLength !== 11'd799) begin n_bad++; $display("FAIL ideal_linelen: got %0d expected 799", lineLength); end
    n_cmp++; if (frameLines !== 10'd6) begin n_bad++; $display("FAIL ideal_framelines: got %0d expected 6", frameLines); end
    n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL ideal_no_syncerr: got %0d pulses expected 0", err_cnt); end
    n_cmp++; if (first_x !== 10'd0) begin n_bad++; $display("FAIL ideal_first_x: got %0d expected 0", first_x); end
    n_cmp++; if (first_y !== 10'd0) begin n_bad++; $display("FAIL ideal_first_y: got %0d expected 0", first_y); end
    n_cmp++; if (first_v !== 1'b1) begin n_bad++; $display("FAIL ideal_first_valid: got %0b expected 1", first_v); end
    n_cmp++; if (last_x !== 10'd639) begin n_bad++; $display("FAIL ideal_last_x: got %0d expected 639", last_x); end
    n_cmp++; if (last_y !== 10'd2) begin n_bad++; $display("FAIL ideal_last_y: got %0d expected 2", last_y); end
  endtask

  task automatic test_small_lock();
    do_reset();
    g_len = 40; g_hsw = 5; g_acts = 10; g_hact = 24; g_vact = 8;
    repeat (3) send_frame(12, -1);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL small_unlocked_pre: got %0b expected 0", locked); end
    lock_rise_cyc = -1;
    send_frame(12, -1);
    n_cmp++; if (lock_rise_cyc !== frame_cyc) begin n_bad++; $display("FAIL small_lock_cycle: got %0d expected %0d", lock_rise_cyc, frame_cyc); end
    n_cmp++; if (lineLength !== 11'd40) begin n_bad++; $display("FAIL small_linelen: got %0d expected 40", lineLength); end
    n_cmp++; if (frameLines !== 10'd12) begin n_bad++; $display("FAIL small_framelines: got %0d expected 12", frameLines); end
    n_cmp++; if (last_x !== 10'd23 || last_y !== 10'd7) begin n_bad++; $display("FAIL small_last_xy: got %0d,%0d expected 23,7", last_x, last_y); end
  endtask

  task automatic test_stretch();
    int e0;
    e0 = err_cnt;
    send_frame(12, 5);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL stretch_pulse_count: got %0d expected 1", err_cnt - e0); end
    n_cmp++; if (err_cyc !== line_cyc[6]) begin n_bad++; $display("FAIL stretch_pulse_cycle: got %0d expected %0d", err_cyc, line_cyc[6]); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL stretch_unlocked: got %0b expected 0", locked); end
    repeat (3) send_frame(12, -1);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL stretch_relock_early: got %0b expected 0", locked); end
    lock_rise_cyc = -1;
    send_frame(12, -1);
    n_cmp++; if (lock_rise_cyc !== frame_cyc) begin n_bad++; $display("FAIL stretch_relock_cycle: got %0d expected %0d", lock_rise_cyc, frame_cyc); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL stretch_single_pulse: got %0d expected 1", err_cnt - e0); end
  endtask

  task automatic test_short_frame();
    int e0;
    e0 = err_cnt;
    send_frame(11, -1);
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL short_no_early_err: got %0d expected 0", err_cnt - e0); end
    send_frame(12, -1);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL short_pulse_count: got %0d expected 1", err_cnt - e0); end
    n_cmp++; if (err_cyc !== frame_cyc) begin n_bad++; $display("FAIL short_pulse_cycle: got %0d expected %0d", err_cyc, frame_cyc); end
    n_cmp++; if (frameLines !== 10'd11) begin n_bad++; $display("FAIL short_framelines: got %0d expected 11", frameLines); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL short_unlocked: got %0b expected 0", locked); end
    repeat (3) send_frame(12, -1);
    lock_rise_cyc = -1;
    send_frame(12, -1);
    n_cmp++; if (lock_rise_cyc !== frame_cyc) begin n_bad++; $display("FAIL short_relock_cycle: got %0d expected %0d", lock_rise_cyc, frame_cyc); end
  endtask

  task automatic test_timeout();
    int e0, last_hfall;
    e0 = err_cnt;
    last_hfall = line_cyc[11];
    repeat (2100) drive(1'b1, 1'b1, 1'b0);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL timeout_pulse_count: got %0d expected 1", err_cnt - e0); end
    n_cmp++; if (err_cyc !== last_hfall + 2048) begin n_bad++; $display("FAIL timeout_pulse_cycle: got %0d expected %0d", err_cyc, last_hfall + 2048); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL timeout_unlocked: got %0b expected 0", locked); end
    n_cmp++; if (lineLength !== 11'd40) begin n_bad++; $display("FAIL timeout_linelen_hold: got %0d expected 40", lineLength); end
  endtask

  task automatic test_reset_midline();
    repeat (3) send_frame(12, -1);
    lock_rise_cyc = -1;
    send_frame(12, -1);
    n_cmp++; if (lock_rise_cyc !== frame_cyc) begin n_bad++; $display("FAIL midrst_prelock_cycle: got %0d expected %0d", lock_rise_cyc, frame_cyc); end
    repeat (5) drive(1'b0, 1'b1, 1'b0);
    repeat (15) drive(1'b1, 1'b1, 1'b1);
    #3 Reset_n = 1'b0;
    #1;
    n_cmp++; if (Xpixel !== 10'd0 || Ypixel !== 10'd0 || pixelValid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_coords: got %0d,%0d,%0b expected 0,0,0", Xpixel, Ypixel, pixelValid); end
    n_cmp++; if (lineLength !== 11'd0 || frameLines !== 10'd0) begin
      n_bad++; $display("FAIL midrst_measure: got %0d,%0d expected 0,0", lineLength, frameLines); end
    n_cmp++; if (locked !== 1'b0 || syncError !== 1'b0) begin
      n_bad++; $display("FAIL midrst_lock: got %0b,%0b expected 0,0", locked, syncError); end
    displayON = 1'b0;
    @(posedge PixelClock); #1;
    Reset_n = 1'b1;
    repeat (3) send_frame(12, -1);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL midrst_relock_early: got %0b expected 0", locked); end
    lock_rise_cyc = -1;
    send_frame(12, -1);
    n_cmp++; if (lock_rise_cyc !== frame_cyc) begin n_bad++; $display("FAIL midrst_relock_cycle: got %0d expected %0d", lock_rise_cyc, frame_cyc); end
  endtask

  initial begin
    Reset_n = 1'b1; Hsync = 1'b1; Vsync = 1'b1; displayON = 1'b0;
    cyc = 0; err_cnt = 0; err_cyc = -1; lock_rise_cyc = -1; prev_locked = 1'b0;
    frame_cyc = 0;
    test_reset();
    test_ideal();
    test_small_lock();
    test_stretch();
    test_short_frame();
    test_timeout();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
